dwrr4_sched: RTL and testbench



---
 rtl/dwrr_pkg.sv | 24 ++
 rtl/dwrr4_sched.sv | 146 ++++++++++++++
 tb/tb_dwrr4_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dwrr_pkg.sv
// Shared types and helpers for the four-queue DWRR scheduler.
//   state_e  : scheduler FSM encoding
//   *_DEF    : default widths and limits for dwrr4_sched
//   sat_add  : width-generic saturating add used for deficit replenish
package dwrr_pkg;

  typedef enum logic [1:0] {IDLE, VISIT, CHECK, GRANT} state_e;

  localparam int unsigned NUM_Q         = 4;
  localparam int unsigned LEN_W_DEF     = 13;
  localparam int unsigned DEF_W_DEF     = 14;
  localparam int unsigned MAX_BURST_DEF = 16;

  // Operands are narrow counters (well under 31 bits), so the 32-bit sum
  // cannot wrap before it is clamped.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_v);
    int unsigned sum;
    sum = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/dwrr4_sched.sv
// Four-queue byte-fair deficit weighted round-robin scheduler.
// One grant per packet is offered to the TX engine over gnt_val/gnt_rdy.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req[3:0]        per-queue head packet present
//   pkt_len         head-packet length per queue, queue i at [i*LEN_W +: LEN_W]
//   quantum         per-visit byte quantum per queue, same packing
//   gnt_rdy         TX engine accepts the current grant
//   gnt_val/id/len  grant valid, queue index, latched packet length
module dwrr4_sched
  import dwrr_pkg::*;
#(
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned DEF_W     = DEF_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_Q-1:0]       req,
  input  logic [NUM_Q*LEN_W-1:0] pkt_len,
  input  logic [NUM_Q*LEN_W-1:0] quantum,
  input  logic                   gnt_rdy,
  output logic                   gnt_val,
  output logic [1:0]             gnt_id,
  output logic [LEN_W-1:0]       gnt_len
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned DEF_MAX = (32'd1 << DEF_W) - 32'd1;

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 gnt_val_q, gnt_val_d;
  logic [1:0]           gnt_id_q, gnt_id_d;
  logic [LEN_W-1:0]     gnt_len_q, gnt_len_d;

  logic [DEF_W-1:0]     def_q [NUM_Q];
  logic [DEF_W-1:0]     def_d [NUM_Q];
  logic [LEN_W-1:0]     len_a [NUM_Q];
  logic [LEN_W-1:0]     quant_a [NUM_Q];

  // Per-queue unpacking and deficit counters.
  for (genvar g = 0; g < NUM_Q; g++) begin : g_q
    logic [DEF_W-1:0] cnt_q;

    assign len_a[g]   = pkt_len[g*LEN_W +: LEN_W];
    assign quant_a[g] = quantum[g*LEN_W +: LEN_W];
    assign def_q[g]   = cnt_q;

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= def_d[g];
    end
  end

  logic [DEF_W-1:0] def_cur;
  logic [LEN_W-1:0] len_cur;
  logic [LEN_W-1:0] quant_cur;

  assign def_cur   = def_q[ptr_q];
  assign len_cur   = len_a[ptr_q];
  assign quant_cur = quant_a[ptr_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    gnt_val_d = gnt_val_q;
    gnt_id_d  = gnt_id_q;
    gnt_len_d = gnt_len_q;
    def_d     = def_q;

    unique case (state_q)
      IDLE: begin
        if (req != '0) state_d = VISIT;
      end

      VISIT: begin
        if (req[ptr_q]) begin
          def_d[ptr_q] = DEF_W'(sat_add(32'(def_cur), 32'(quant_cur), DEF_MAX));
          burst_d      = '0;
          state_d      = CHECK;
        end else begin
          def_d[ptr_q] = '0;
          ptr_d        = ptr_q + 2'd1;
          state_d      = (req != '0) ? VISIT : IDLE;
        end
      end

      CHECK: begin
        if (!req[ptr_q]) begin
          // An emptied queue forfeits whatever deficit it had built up.
          def_d[ptr_q] = '0;
          ptr_d        = ptr_q + 2'd1;
          state_d      = (req != '0) ? VISIT : IDLE;
        end else if ((burst_q < BURST_W'(MAX_BURST)) &&
                     (def_cur >= DEF_W'(len_cur))) begin
          gnt_val_d = 1'b1;
          gnt_id_d  = ptr_q;
          gnt_len_d = len_cur;
          state_d   = GRANT;
        end else begin
          ptr_d   = ptr_q + 2'd1;
          state_d = VISIT;
        end
      end

      GRANT: begin
        // Charge the latched length, not the live pkt_len, so upstream
        // changes during the handshake cannot skew the accounting.
        if (gnt_rdy) begin
          def_d[ptr_q] = def_cur - DEF_W'(gnt_len_q);
          burst_d      = burst_q + BURST_W'(1);
          gnt_val_d    = 1'b0;
          state_d      = CHECK;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      burst_q   <= '0;
      gnt_val_q <= 1'b0;
      gnt_id_q  <= '0;
      gnt_len_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      gnt_val_q <= gnt_val_d;
      gnt_id_q  <= gnt_id_d;
      gnt_len_q <= gnt_len_d;
    end
  end

  assign gnt_val = gnt_val_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_len = gnt_len_q;

endmodule

// File: tb/tb_dwrr4_sched.sv
module tb_dwrr4_sched;

  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [4*LW-1:0] pkt_len;
  logic [4*LW-1:0] quantum;
  logic          gnt_rdy;
  logic          gnt_val;
  logic [1:0]    gnt_id;
  logic [LW-1:0] gnt_len;

  int errors = 0;
  int checks = 0;

  dwrr4_sched #(.LEN_W(13), .DEF_W(14), .MAX_BURST(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pkt_len (pkt_len),
    .quantum (quantum),
    .gnt_rdy (gnt_rdy),
    .gnt_val (gnt_val),
    .gnt_id  (gnt_id),
    .gnt_len (gnt_len)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_q(input int i, input int q, input int l);
    quantum[i*LW +: LW] = LW'(q);
    pkt_len[i*LW +: LW] = LW'(l);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    gnt_rdy = 1'b0;
    pkt_len = '0;
    quantum = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge where a grant will transfer on the next posedge.
  task automatic wait_grant(output logic [1:0] id, output logic [LW-1:0] len, output logic ok);
    ok  = 1'b0;
    id  = '0;
    len = '0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (gnt_val && gnt_rdy) begin
        id  = gnt_id;
        len = gnt_len;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_val(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (gnt_val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("val_timeout", 32'(ok), 32'd1);
  endtask

  // Counts rising edges from IDLE until gnt_val is seen.
  task automatic wait_first(output int edges);
    edges = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (gnt_val) break;
    end
  endtask

  initial begin
    logic [1:0]    id;
    logic [LW-1:0] len;
    logic          ok;
    int            edges;
    int            bytes [4];
    int            exp2 [23];
    int            exp4 [11];
    int            exp5 [20];
    int            exp6 [5];
    logic          stable;
    logic [1:0]    id0;
    logic [LW-1:0] len0;

    // ---- Test 1: equal quantum/length, strict rotation ----
    do_reset();
    check("rst_val", 32'(gnt_val), 32'd0);
    check("rst_id",  32'(gnt_id),  32'd0);
    check("rst_len", 32'(gnt_len), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_q(i, 1024, 1024);
    gnt_rdy = 1'b1;
    req     = 4'hF;
    wait_first(edges);
    check("t1_latency", 32'(edges), 32'd3);
    check("t1_first_id",  32'(gnt_id),  32'd0);
    check("t1_first_len", 32'(gnt_len), 32'd1024);
    for (int k = 1; k < 8; k++) begin
      wait_grant(id, len, ok);
      if (!ok) break;
      check($sformatf("t1_id%0d", k),  32'(id),  32'(k % 4));
      check($sformatf("t1_len%0d", k), 32'(len), 32'd1024);
    end

    // ---- Test 2: byte fairness across different PMTUs ----
    do_reset();
    rst = 1'b0;
    set_q(0, 4096, 1024);
    set_q(1, 4096, 2048);
    set_q(2, 4096, 256);
    set_q(3, 4096, 4096);
    for (int k = 0; k < 23; k++)
      exp2[k] = (k < 4) ? 0 : (k < 6) ? 1 : (k < 22) ? 2 : 3;
    for (int i = 0; i < 4; i++) bytes[i] = 0;
    gnt_rdy = 1'b1;
    req     = 4'hF;
    ok      = 1'b1;
    for (int r = 0; r < 100 && ok; r++) begin
      for (int k = 0; k < 23; k++) begin
        wait_grant(id, len, ok);
        if (!ok) break;
        if (r == 0) check($sformatf("t2_r0_id%0d", k), 32'(id), 32'(exp2[k]));
        bytes[id] += int'(len);
      end
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_bytes_q%0d", i), 32'(bytes[i]), 32'd409600);

    // ---- Test 3: grant held stable under back-pressure ----
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_q(i, 1024, 1024);
    req = 4'hF;
    wait_val(ok);
    id0    = gnt_id;
    len0   = gnt_len;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        set_q(0, 1024, 512);
        req = 4'b1011;
      end
      if (gnt_val !== 1'b1 || gnt_id !== id0 || gnt_len !== len0) stable = 1'b0;
    end
    check("t3_stable", 32'(stable), 32'd1);
    check("t3_id",  32'(id0),  32'd0);
    check("t3_len", 32'(len0), 32'd1024);
    gnt_rdy = 1'b1;
    @(negedge clk);
    gnt_rdy = 1'b0;
    check("t3_one_xfer", 32'(gnt_val), 32'd0);
    req     = 4'hF;
    gnt_rdy = 1'b1;
    wait_grant(id, len, ok);
    check("t3_next_id",  32'(id),  32'd1);
    check("t3_next_len", 32'(len), 32'd1024);

    // ---- Test 4: small quantum needs two visits; emptying forfeits ----
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_q(i, 1024, 1024);
    set_q(1, 512, 1024);
    exp4 = '{0, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1};
    gnt_rdy = 1'b1;
    req     = 4'hF;
    for (int k = 0; k < 11; k++) begin
      wait_grant(id, len, ok);
      if (!ok) break;
      check($sformatf("t4_id%0d", k), 32'(id), 32'(exp4[k]));
      if (k == 3) req = 4'b1101;
      if (k == 4) req = 4'hF;
    end

    // ---- Test 5: zero-length packets bounded by burst cap ----
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_q(i, 1024, 1024);
    set_q(2, 0, 0);
    for (int k = 0; k < 20; k++)
      exp5[k] = (k == 0) ? 0 : (k == 1) ? 1 : (k < 18) ? 2 : (k == 18) ? 3 : 0;
    gnt_rdy = 1'b1;
    req     = 4'hF;
    for (int k = 0; k < 20; k++) begin
      wait_grant(id, len, ok);
      if (!ok) break;
      check($sformatf("t5_id%0d", k),  32'(id),  32'(exp5[k]));
      check($sformatf("t5_len%0d", k), 32'(len), (exp5[k] == 2) ? 32'd0 : 32'd1024);
    end

    // ---- Test 6: reset with an outstanding grant ----
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_q(i, 2048, 1024);
    gnt_rdy = 1'b1;
    req     = 4'hF;
    for (int k = 0; k < 2; k++) begin
      wait_grant(id, len, ok);
      check($sformatf("t6_pre_id%0d", k), 32'(id), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    gnt_rdy = 1'b0;
    wait_val(ok);
    check("t6_held_id", 32'(gnt_id), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_val", 32'(gnt_val), 32'd0);
    check("t6_rst_id",  32'(gnt_id),  32'd0);
    check("t6_rst_len", 32'(gnt_len), 32'd0);
    rst     = 1'b0;
    gnt_rdy = 1'b1;
    wait_first(edges);
    check("t6_latency", 32'(edges), 32'd3);
    exp6 = '{0, 0, 1, 1, 2};
    check("t6_id0", 32'(gnt_id), 32'(exp6[0]));
    for (int k = 1; k < 5; k++) begin
      wait_grant(id, len, ok);
      if (!ok) break;
      check($sformatf("t6_id%0d", k), 32'(id), 32'(exp6[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
